// File: rtl/clock_pkg.sv
// Shared constants, alarm state type and display helpers for the time-of-day core.
package clock_pkg;

  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int HOUR_MOD = 24;

  typedef enum logic {
    IDLE = 1'b0,
    RING = 1'b1
  } alarm_state_t;

  // Binary 0..59 to packed {tens, ones} BCD.
  function automatic logic [7:0] bin2bcd8(input logic [6:0] bin);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(bin / 7'd10);
    ones = 4'(bin % 7'd10);
    return {tens, ones};
  endfunction

  // Internal 0..23 hour to 12 h clock-face hour 1..12.
  function automatic logic [4:0] to12h(input logic [4:0] hour);
    if (hour == 5'd0) begin
      return 5'd12;
    end else if (hour > 5'd12) begin
      return hour - 5'd12;
    end else begin
      return hour;
    end
  endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N counter taking two simultaneous increments; only inc_a can carry out.
module mod_n_counter #(
  parameter int N = 60,
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_a,
  input  logic         inc_b,
  output logic [W-1:0] value,
  output logic [W-1:0] next_value,
  output logic         carry_out
);

  localparam logic [W:0]   MOD  = N[W:0];
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W:0] sum;

  // Both increments can land on N-1 together, so the sum may overshoot by up to 1 past N.
  assign sum        = {1'b0, value} + {{W{1'b0}}, inc_a} + {{W{1'b0}}, inc_b};
  assign next_value = (sum >= MOD) ? W'(sum - MOD) : sum[W-1:0];
  assign carry_out  = inc_a && (value == LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      value <= '0;
    end else begin
      value <= next_value;
    end
  end

endmodule

// File: rtl/clock_core_sync.sv
// Time-of-day core: prescaled tick, h/m/s counters, BCD display registers, one-shot alarm.
//   state | meaning
//   IDLE  | alarm silent, waiting for a tick that lands on the alarm time
//   RING  | alarm asserted, counting ticks until timeout, ack or disarm
module clock_core_sync #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 1,
  parameter int ALARM_SEC = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_tgl,
  input  logic       inc_sec,
  input  logic       inc_min,
  input  logic       inc_hour,
  input  logic       mode12,
  input  logic       alarm_we,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       alarm_en,
  input  logic       alarm_ack,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic       pm,
  output logic       running,
  output logic       tick,
  output logic       alarm
);
  import clock_pkg::*;

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam int RW  = (ALARM_SEC > 1) ? $clog2(ALARM_SEC + 1) : 1;
  localparam logic [RW-1:0] RING_LAST = RW'(ALARM_SEC - 1);

  logic [PW-1:0] presc;
  logic [5:0]    sec_cnt, min_cnt, sec_nx, min_nx;
  logic [4:0]    hour_cnt, hour_nx;
  logic          carry_s, carry_m;
  logic [4:0]    alarm_hour_set;
  logic [5:0]    alarm_min_set;
  logic          alarm_hit;
  alarm_state_t  state;
  logic [RW-1:0] ring_cnt;

  // The phase is held, not cleared, while stopped so the tick cadence resumes seamlessly.
  assign tick = running && (presc == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc   <= '0;
      running <= 1'b1;
    end else begin
      if (running) begin
        presc <= tick ? '0 : presc + 1'b1;
      end
      if (run_tgl) begin
        running <= ~running;
      end
    end
  end

  mod_n_counter #(.N(SEC_MOD), .W(6)) u_sec (
    .clk, .rst, .inc_a(tick), .inc_b(inc_sec),
    .value(sec_cnt), .next_value(sec_nx), .carry_out(carry_s)
  );

  mod_n_counter #(.N(MIN_MOD), .W(6)) u_min (
    .clk, .rst, .inc_a(carry_s), .inc_b(inc_min),
    .value(min_cnt), .next_value(min_nx), .carry_out(carry_m)
  );

  mod_n_counter #(.N(HOUR_MOD), .W(5)) u_hour (
    .clk, .rst, .inc_a(carry_m), .inc_b(inc_hour),
    .value(hour_cnt), .next_value(hour_nx), .carry_out()
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      sec_bcd  <= '0;
      min_bcd  <= '0;
      hour_bcd <= '0;
      pm       <= 1'b0;
    end else begin
      sec_bcd  <= bin2bcd8({1'b0, sec_cnt});
      min_bcd  <= bin2bcd8({1'b0, min_cnt});
      hour_bcd <= bin2bcd8({2'b00, (mode12 ? to12h(hour_cnt) : hour_cnt)});
      pm       <= (hour_cnt >= 5'd12);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      alarm_hour_set <= '0;
      alarm_min_set  <= '0;
    end else if (alarm_we && (alarm_hour <= 5'd23) && (alarm_min <= 6'd59)) begin
      alarm_hour_set <= alarm_hour;
      alarm_min_set  <= alarm_min;
    end
  end

  // Compare against the post-update time so the alarm fires on the tick that reaches hh:mm:00.
  assign alarm_hit = tick && alarm_en && (hour_nx == alarm_hour_set) &&
                     (min_nx == alarm_min_set) && (sec_nx == 6'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      alarm    <= 1'b0;
      ring_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (alarm_hit && !alarm_ack) begin
            state    <= RING;
            alarm    <= 1'b1;
            ring_cnt <= RING_LAST;
          end
        end
        RING: begin
          if (alarm_ack || !alarm_en || (tick && (ring_cnt == '0))) begin
            state <= IDLE;
            alarm <= 1'b0;
          end else if (tick) begin
            ring_cnt <= ring_cnt - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_core_sync.sv
// Randomized and directed bench for clock_core_sync against a seconds-of-day reference model.
module tb_clock_core_sync;

  localparam int DIV       = 4;
  localparam int ALARM_SEC = 30;
  localparam int DAY       = 86400;

  logic       clk = 1'b0;
  logic       rst;
  logic       run_tgl, inc_sec, inc_min, inc_hour, mode12;
  logic       alarm_we, alarm_en, alarm_ack;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic [7:0] sec_bcd, min_bcd, hour_bcd;
  logic       pm, running, tick, alarm;

  always #5 clk = ~clk;

  clock_core_sync #(.CLK_HZ(DIV), .TICK_HZ(1), .ALARM_SEC(ALARM_SEC)) dut (
    .clk(clk), .rst(rst), .run_tgl(run_tgl), .inc_sec(inc_sec), .inc_min(inc_min),
    .inc_hour(inc_hour), .mode12(mode12), .alarm_we(alarm_we), .alarm_hour(alarm_hour),
    .alarm_min(alarm_min), .alarm_en(alarm_en), .alarm_ack(alarm_ack),
    .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hour_bcd(hour_bcd), .pm(pm),
    .running(running), .tick(tick), .alarm(alarm)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: time kept as seconds of the day, alarm as a flag plus ticks seen.
  int   m_t, m_phase, m_ah, m_am, m_ring_ticks;
  bit   m_run, m_ring;
  logic [7:0] e_sec, e_min, e_hour;
  bit   e_pm;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic int face_hour(int h, bit m12);
    if (!m12) return h;
    if (h == 0) return 12;
    return (h > 12) ? h - 12 : h;
  endfunction

  function automatic bit m_tick();
    return m_run && (m_phase == DIV - 1);
  endfunction

  task automatic model_edge();
    int  s, m, h;
    bit  tk, trig;
    if (!rst) begin
      m_t = 0; m_phase = 0; m_run = 1; m_ring = 0; m_ring_ticks = 0;
      m_ah = 0; m_am = 0; e_sec = 0; e_min = 0; e_hour = 0; e_pm = 0;
      return;
    end
    h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
    e_sec  = to_bcd(s);
    e_min  = to_bcd(m);
    e_hour = to_bcd(face_hour(h, mode12));
    e_pm   = (h >= 12);
    tk = m_tick();
    if (m_run) m_phase = (m_phase + 1) % DIV;
    if (run_tgl) m_run = !m_run;
    if (tk) m_t = (m_t + 1) % DAY;
    h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
    s = (s + int'(inc_sec)) % 60;
    m = (m + int'(inc_min)) % 60;
    h = (h + int'(inc_hour)) % 24;
    m_t = h * 3600 + m * 60 + s;
    trig = tk && alarm_en && (m_t == m_ah * 3600 + m_am * 60);
    if (m_ring) begin
      if (tk) m_ring_ticks++;
      if (alarm_ack || !alarm_en || m_ring_ticks == ALARM_SEC) m_ring = 0;
    end else if (trig && !alarm_ack) begin
      m_ring = 1;
      m_ring_ticks = 0;
    end
    if (alarm_we && alarm_hour <= 23 && alarm_min <= 59) begin
      m_ah = int'(alarm_hour);
      m_am = int'(alarm_min);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("sec_bcd", sec_bcd, e_sec);
    check_eq("min_bcd", min_bcd, e_min);
    check_eq("hour_bcd", hour_bcd, e_hour);
    check_eq("pm", pm, e_pm);
    check_eq("running", running, m_run);
    check_eq("tick", tick, m_tick());
    check_eq("alarm", alarm, m_ring);
    run_tgl = 0; inc_sec = 0; inc_min = 0; inc_hour = 0; alarm_we = 0; alarm_ack = 0;
  endtask

  task automatic set_time(int h, int m, int s);
    int n;
    n = (s - m_t % 60 + 60) % 60;
    repeat (n) begin inc_sec = 1; step(); end
    n = (m - (m_t / 60) % 60 + 60) % 60;
    repeat (n) begin inc_min = 1; step(); end
    n = (h - m_t / 3600 + 24) % 24;
    repeat (n) begin inc_hour = 1; step(); end
  endtask

  // Leaves the clock stopped with the prescaler one cycle before its tick.
  task automatic stop_at_last();
    int b;
    b = 0;
    while (!(m_run && m_phase == DIV - 2) && b < 50) begin step(); b++; end
    run_tgl = 1;
    step();
  endtask

  // From a stopped, tick-pending state: preload, restart, let the pending tick land.
  task automatic hit(int h, int m, int s);
    set_time(h, m, s);
    run_tgl = 1;
    step();
    check_eq("restart_tick", tick, 1);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int nt, b, nt2;
    bit saw59;
    rst = 0; run_tgl = 0; inc_sec = 0; inc_min = 0; inc_hour = 0; mode12 = 0;
    alarm_we = 0; alarm_en = 0; alarm_ack = 0; alarm_hour = 0; alarm_min = 0;

    step();
    check_eq("rst_sec", sec_bcd, 8'h00);
    check_eq("rst_hour", hour_bcd, 8'h00);
    check_eq("rst_running", running, 1);
    check_eq("rst_alarm", alarm, 0);
    check_eq("rst_tick", tick, 0);
    rst = 1;

    nt = 0; saw59 = 0;
    repeat (60 * DIV) begin
      step();
      if (tick) nt++;
      if (sec_bcd == 8'h59) saw59 = 1;
    end
    check_eq("tick_count_60", nt, 60);
    check_eq("saw_sec_59", saw59, 1);
    step();
    check_eq("min_after_60", min_bcd, 8'h01);
    check_eq("sec_after_60", sec_bcd, 8'h00);

    stop_at_last();
    set_time(23, 59, 58);
    step();
    check_eq("pre_pm", pm, 1);
    check_eq("pre_hour", hour_bcd, 8'h23);
    run_tgl = 1;
    step();
    nt = tick ? 1 : 0;
    b = 0;
    while (nt < 2 && b < 20) begin step(); if (tick) nt++; b++; end
    step();
    step();
    check_eq("midnight_sec", sec_bcd, 8'h00);
    check_eq("midnight_min", min_bcd, 8'h00);
    check_eq("midnight_hour", hour_bcd, 8'h00);
    check_eq("midnight_pm", pm, 0);
    mode12 = 1;
    step();
    check_eq("mode12_hour", hour_bcd, 8'h12);
    mode12 = 0;

    stop_at_last();
    check_eq("stopped_running", running, 0);
    nt = 0;
    repeat (100) begin step(); if (tick) nt++; end
    check_eq("stopped_ticks", nt, 0);
    check_eq("still_stopped", running, 0);
    run_tgl = 1;
    step();
    check_eq("first_tick_after_restart", tick, 1);

    stop_at_last();
    set_time(10, 20, 59);
    inc_sec = 1; step(); step();
    check_eq("inc59_sec", sec_bcd, 8'h00);
    check_eq("inc59_min", min_bcd, 8'h20);
    set_time(10, 20, 58);
    run_tgl = 1; step();
    inc_sec = 1; step(); step();
    check_eq("tick_inc_sec", sec_bcd, 8'h00);
    check_eq("tick_inc_min", min_bcd, 8'h20);
    stop_at_last();
    set_time(10, 59, 0);
    inc_min = 1; step(); step();
    check_eq("incmin_min", min_bcd, 8'h00);
    check_eq("incmin_hour", hour_bcd, 8'h10);

    alarm_hour = 5'd7; alarm_min = 6'd30; alarm_we = 1; step();
    alarm_en = 1;
    hit(7, 29, 59);
    check_eq("alarm_ring", alarm, 1);
    alarm_ack = 1; step();
    check_eq("alarm_ack", alarm, 0);

    stop_at_last();
    hit(7, 29, 59);
    check_eq("alarm_ring2", alarm, 1);
    nt = 0; b = 0;
    while (alarm && b < (ALARM_SEC + 2) * DIV) begin
      if (tick) nt++;
      step();
      b++;
    end
    check_eq("alarm_timeout_clear", alarm, 0);
    check_eq("alarm_timeout_ticks", nt, ALARM_SEC);

    alarm_hour = 5'd8; alarm_min = 6'd60; alarm_we = 1; step();
    stop_at_last();
    hit(7, 29, 59);
    check_eq("oor_write_dropped", alarm, 1);
    alarm_hour = 5'd8; alarm_min = 6'd0; alarm_we = 1; step();
    check_eq("we_during_ring", alarm, 1);
    alarm_ack = 1; step();

    stop_at_last();
    alarm_hour = 5'd13; alarm_min = 6'd5; alarm_we = 1; step();
    hit(13, 4, 59);
    check_eq("ring_1305", alarm, 1);
    b = 0;
    while (m_t != 13 * 3600 + 5 * 60 + 10 && b < 200) begin step(); b++; end
    check_eq("ring_at_130510", alarm, 1);
    rst = 0; step(); rst = 1;
    check_eq("rst_ring_alarm", alarm, 0);
    check_eq("rst_ring_running", running, 1);
    check_eq("rst_ring_sec", sec_bcd, 8'h00);
    check_eq("rst_ring_min", min_bcd, 8'h00);
    check_eq("rst_ring_hour", hour_bcd, 8'h00);
    check_eq("rst_ring_pm", pm, 0);

    for (int i = 0; i < 4000; i++) begin
      run_tgl   = ($urandom_range(0, 63) == 0);
      inc_sec   = ($urandom_range(0, 15) == 0);
      inc_min   = ($urandom_range(0, 31) == 0);
      inc_hour  = ($urandom_range(0, 31) == 0);
      alarm_ack = ($urandom_range(0, 47) == 0);
      if ($urandom_range(0, 255) == 0) mode12 = !mode12;
      if ($urandom_range(0, 149) == 0) alarm_en = !alarm_en;
      alarm_we = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 1) == 0) begin
        nt2 = (m_t + 60) % DAY;
        alarm_hour = 5'(nt2 / 3600);
        alarm_min  = 6'((nt2 / 60) % 60);
      end else begin
        alarm_hour = 5'($urandom_range(0, 31));
        alarm_min  = 6'($urandom_range(0, 63));
      end
      rst = ($urandom_range(0, 999) != 0);
      step();
    end
    rst = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
